nios_system_dpram_pipelined: RTL and testbench
==============================================

# nios_system_dpram_pipelined

Parametrised dual-port on-chip RAM. It presents two independent Avalon-MM slave ports (s1, s2) onto one shared memory array. It adds selectable read latency, `readdatavalid` signalling, `waitrequest`-based write-collision arbitration, out-of-range address handling, and a saturating collision counter. It sits in the Nios II system as a general-purpose shared buffer between the CPU data master and a DMA or streaming master.

## Interface
- `DATA_WIDTH`, 32: word width in bits; a multiple of 8.
- `ADDR_WIDTH`, 10: word address width.
- `DEPTH`, 1024: number of words; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: 1 = array output only; 2 = additional output register. Any other value is illegal.
- `INIT_FILE`, "nios_system_dpram_pipelined.hex": memory initialisation file.
- `clk` in 1: single clock for both ports.
- `reset_n` in 1: asynchronous, active-low reset. Resets control state only; array contents are preserved.
- `reset_req` in 1: synchronous freeze request; while high, no command is accepted on either port.
- `sN_address` in ADDR_WIDTH: word address (N = 1, 2; applies to every `sN_` port below).
- `sN_byteenable` in DATA_WIDTH/8: write byte lanes.
- `sN_chipselect`, `sN_read`, `sN_write` in 1: Avalon command qualifiers.
- `sN_clken` in 1: port enable; when low, that port accepts no command.
- `sN_writedata` in DATA_WIDTH: write data.
- `sN_readdata` out DATA_WIDTH: read data, valid only when `sN_readdatavalid` is high.
- `sN_readdatavalid` out 1: single-cycle pulse per accepted read.
- `sN_waitrequest` out 1: command stall.
- `collision_count` out 16: saturating count of s2 stalls caused by collisions.

## Operation
- Request on port N: `sN_chipselect & (sN_read | sN_write)`.
- Acceptance on port N: request & `~sN_waitrequest`.
- `sN_waitrequest` is combinational: `~reset_n | reset_req | ~sN_clken | lossN`.
  - `loss1` is always 0.
  - `loss2` = both ports requesting a write, same address, and s1 not stalled.
- Collision: s1 always wins. s2 stalls until the collision clears, then is accepted.
- Each cycle in which `loss2` = 1 increments `collision_count`. The counter saturates at 16'hFFFF.
- If read and write are both high on one port, the command is a write. No `readdatavalid` is produced.
- Writes update only the lanes enabled in `sN_byteenable`. A byteenable of all zeros is accepted and changes nothing.
- Address ≥ DEPTH:
  - Write: accepted and discarded.
  - Read: accepted and returns all-zero data with a normal `readdatavalid`.
- Mixed-port read-during-write (one port reads the address the other port writes in the same cycle): the read returns OLD data.
- Non-colliding writes on both ports in the same cycle both complete.
- Read pipeline per port is a READ_LATENCY-deep valid/data shift. It always advances and is not gated by `sN_clken` or `reset_req`, so in-flight reads still complete.
- The ports are fully pipelined: one accepted read per cycle per port is sustained.

## Timing
- Read accepted at cycle T → `sN_readdatavalid` = 1 with data at cycle T+READ_LATENCY, for exactly one cycle.
- A write accepted at cycle T is visible to a read accepted at T+1 on either port.
- Reset values: `sN_readdata` = 0, `sN_readdatavalid` = 0, `collision_count` = 0. `sN_waitrequest` = 1 while `reset_n` is low.
- Reset asserted mid-operation: in-flight reads are dropped and no `readdatavalid` is emitted for them. A write accepted in the cycle before reset is asserted still completes.
- Deassertion of `reset_n` is synchronised internally. The first command is accepted no earlier than the second rising edge after release.
- When `sN_readdatavalid` = 0, `sN_readdata` holds its last value.

## Test plan
- READ_LATENCY=1: s1 writes 0xDEADBEEF to address 5 at T0, s2 reads address 5 at T1 → `s2_readdatavalid` at T2 with data 0xDEADBEEF. Repeat with READ_LATENCY=2 → valid at T3.
- Collision: both ports write address 0x3FF at T0 (s1 = 0x11111111, s2 = 0x22222222) → `s2_waitrequest` = 1 at T0 and s2 is accepted at T1. Final word = 0x22222222 and `collision_count` = 1.
- Mixed read-during-write: word 7 = 0xAAAAAAAA; s1 writes 0x55555555 to address 7 while s2 reads address 7 → s2 returns 0xAAAAAAAA. A re-read returns 0x55555555.
- Byte enables: word 0 = 0x00000000; s1 writes 0xFFFFFFFF with byteenable = 4'b0101 → readback 0x00FF00FF.
- Out of range with DEPTH=1000: write 0x12345678 to address 1000, then read address 1000 → data 0, `readdatavalid` = 1, and words 0 and 999 are unchanged.
- Back-to-back reads plus reset: 16 consecutive reads on s1 give 16 valid pulses in order. Asserting `reset_n` low mid-burst forces outputs to 0 immediately. After release, `collision_count` = 0 and memory contents are intact.

Source files
------------

// File: rtl/nios_system_dpram_pipelined.sv
// rtl/nios_system_dpram_pipelined.sv - dual-port Avalon-MM RAM with pipelined reads and write-collision arbitration
// s1 always wins a same-address write collision; s2 stalls via waitrequest until it clears.
module nios_system_dpram_pipelined #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = "nios_system_dpram_pipelined.hex"
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    reset_req,
   input  logic [ADDR_WIDTH-1:0]   s1_address,
   input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
   input  logic                    s1_chipselect,
   input  logic                    s1_read,
   input  logic                    s1_write,
   input  logic                    s1_clken,
   input  logic [DATA_WIDTH-1:0]   s1_writedata,
   output logic [DATA_WIDTH-1:0]   s1_readdata,
   output logic                    s1_readdatavalid,
   output logic                    s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]   s2_address,
   input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
   input  logic                    s2_chipselect,
   input  logic                    s2_read,
   input  logic                    s2_write,
   input  logic                    s2_clken,
   input  logic [DATA_WIDTH-1:0]   s2_writedata,
   output logic [DATA_WIDTH-1:0]   s2_readdata,
   output logic                    s2_readdatavalid,
   output logic                    s2_waitrequest,
   output logic [15:0]             collision_count
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int RL = (READ_LATENCY == 2) ? 2 : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] addr  [2];
   logic [BW-1:0]         be    [2];
   logic [DATA_WIDTH-1:0] wdata [2];
   logic [1:0] cs, rd, wr, ce, req, stall, acc, acc_wr, acc_rd, in_range;
   logic       port_block, loss2;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  rst_meta_q, rst_ready_q;
   logic [RL-1:0]         rv_q [2];
   logic [DATA_WIDTH-1:0] rd_q [2][RL];
   logic [15:0]           coll_q, coll_d;

   assign addr[0]  = s1_address;
   assign addr[1]  = s2_address;
   assign be[0]    = s1_byteenable;
   assign be[1]    = s2_byteenable;
   assign wdata[0] = s1_writedata;
   assign wdata[1] = s2_writedata;
   assign cs       = {s2_chipselect, s1_chipselect};
   assign rd       = {s2_read, s1_read};
   assign wr       = {s2_write, s1_write};
   assign ce       = {s2_clken, s1_clken};

   // rst_ready_q keeps both ports stalled for two edges after reset release
   assign port_block  = ~reset_n | reset_req | ~rst_ready_q;
   assign stall[0]    = port_block | ~ce[0];
   assign loss2       = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]) & ~stall[0];
   assign stall[1]    = port_block | ~ce[1] | loss2;
   assign in_range[0] = {1'b0, addr[0]} < DEPTH_W;
   assign in_range[1] = {1'b0, addr[1]} < DEPTH_W;
   assign req         = cs & (rd | wr);
   assign acc         = req & ~stall;
   assign acc_wr      = acc & wr & in_range;
   assign acc_rd      = acc & rd & ~wr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta_q  <= 1'b0;
         rst_ready_q <= 1'b0;
      end else begin
         rst_meta_q  <= 1'b1;
         rst_ready_q <= rst_meta_q;
      end
   end

   // Array has no reset so contents survive reset_n
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (acc_wr[p]) begin
            for (int b = 0; b < BW; b++) begin
               if (be[p][b]) mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < 2; p++) begin
            rv_q[p] <= '0;
            for (int k = 0; k < RL; k++) rd_q[p][k] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            rv_q[p][0] <= acc_rd[p];
            if (acc_rd[p]) rd_q[p][0] <= in_range[p] ? mem[addr[p]] : '0;
            for (int k = 1; k < RL; k++) begin
               rv_q[p][k] <= rv_q[p][k-1];
               if (rv_q[p][k-1]) rd_q[p][k] <= rd_q[p][k-1];
            end
         end
      end
   end

   always_comb begin
      coll_d = coll_q;
      if (loss2 && coll_q != 16'hFFFF) coll_d = coll_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) coll_q <= '0;
      else          coll_q <= coll_d;
   end

   assign s1_readdata      = rd_q[0][RL-1];
   assign s1_readdatavalid = rv_q[0][RL-1];
   assign s1_waitrequest   = stall[0];
   assign s2_readdata      = rd_q[1][RL-1];
   assign s2_readdatavalid = rv_q[1][RL-1];
   assign s2_waitrequest   = stall[1];
   assign collision_count  = coll_q;

endmodule

// File: tb/tb_nios_system_dpram_pipelined.sv
// tb/tb_nios_system_dpram_pipelined.sv - bench for nios_system_dpram_pipelined
// Two instances share stimulus: a (latency 1, 1000 words) and b (latency 2, 1024 words).
module tb_nios_system_dpram_pipelined;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n = 1'b0;
   logic        reset_req = 1'b0;
   logic [9:0]  s_addr [2];
   logic [3:0]  s_be   [2];
   logic        s_cs   [2];
   logic        s_rd   [2];
   logic        s_wr   [2];
   logic        s_ce   [2];
   logic [31:0] s_wd   [2];

   logic [31:0] a1_rd, a2_rd, b1_rd, b2_rd;
   logic        a1_v, a2_v, b1_v, b2_v, a1_w, a2_w, b1_w, b2_w;
   logic [15:0] a_cnt, b_cnt;

   logic [31:0] o_rd [2][2];
   logic        o_v  [2][2];
   logic        o_w  [2][2];
   logic [15:0] o_cnt [2];

   int total = 0;
   int bad = 0;

   nios_system_dpram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
      .s1_address(s_addr[0]), .s1_byteenable(s_be[0]), .s1_chipselect(s_cs[0]), .s1_read(s_rd[0]),
      .s1_write(s_wr[0]), .s1_clken(s_ce[0]), .s1_writedata(s_wd[0]),
      .s1_readdata(a1_rd), .s1_readdatavalid(a1_v), .s1_waitrequest(a1_w),
      .s2_address(s_addr[1]), .s2_byteenable(s_be[1]), .s2_chipselect(s_cs[1]), .s2_read(s_rd[1]),
      .s2_write(s_wr[1]), .s2_clken(s_ce[1]), .s2_writedata(s_wd[1]),
      .s2_readdata(a2_rd), .s2_readdatavalid(a2_v), .s2_waitrequest(a2_w),
      .collision_count(a_cnt));

   nios_system_dpram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1024), .READ_LATENCY(2)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
      .s1_address(s_addr[0]), .s1_byteenable(s_be[0]), .s1_chipselect(s_cs[0]), .s1_read(s_rd[0]),
      .s1_write(s_wr[0]), .s1_clken(s_ce[0]), .s1_writedata(s_wd[0]),
      .s1_readdata(b1_rd), .s1_readdatavalid(b1_v), .s1_waitrequest(b1_w),
      .s2_address(s_addr[1]), .s2_byteenable(s_be[1]), .s2_chipselect(s_cs[1]), .s2_read(s_rd[1]),
      .s2_write(s_wr[1]), .s2_clken(s_ce[1]), .s2_writedata(s_wd[1]),
      .s2_readdata(b2_rd), .s2_readdatavalid(b2_v), .s2_waitrequest(b2_w),
      .collision_count(b_cnt));

   always_comb begin
      o_rd[0][0] = a1_rd; o_rd[0][1] = a2_rd; o_rd[1][0] = b1_rd; o_rd[1][1] = b2_rd;
      o_v[0][0]  = a1_v;  o_v[0][1]  = a2_v;  o_v[1][0]  = b1_v;  o_v[1][1]  = b2_v;
      o_w[0][0]  = a1_w;  o_w[0][1]  = a2_w;  o_w[1][0]  = b1_w;  o_w[1][1]  = b2_w;
      o_cnt[0]   = a_cnt; o_cnt[1]   = b_cnt;
   end

   // Reference model: memory per instance plus a schedule of read results keyed by output edge
   bit [31:0] mmem [2][1024];
   bit        sv   [2][2][8];
   bit [31:0] sdat [2][2][8];
   bit [31:0] last [2][2];
   bit        m_acc [2];
   int        mcnt = 0;
   int        ready = 0;
   int        edge_n = 0;
   bit        chk_en = 1'b0;

   function automatic int dep(int d);
      return (d == 0) ? 1000 : 1024;
   endfunction

   function automatic bit s1_stall();
      return !reset_n || reset_req || !s_ce[0] || ready < 2;
   endfunction

   function automatic bit m_loss();
      return s_cs[0] && s_wr[0] && s_cs[1] && s_wr[1] && (s_addr[0] == s_addr[1]) && !s1_stall();
   endfunction

   function automatic bit m_wait(int p);
      if (p == 0) return s1_stall();
      return !reset_n || reset_req || !s_ce[1] || ready < 2 || m_loss();
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready = 0;
         mcnt = 0;
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
               last[d][p] = '0;
               for (int s = 0; s < 8; s++) sv[d][p][s] = 1'b0;
            end
      end else begin
         for (int p = 0; p < 2; p++) m_acc[p] = s_cs[p] && (s_rd[p] || s_wr[p]) && !m_wait(p);
         if (m_loss() && mcnt < 65535) mcnt++;
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
               if (m_acc[p] && s_rd[p] && !s_wr[p]) begin
                  sv[d][p][(edge_n + d) % 8]   = 1'b1;
                  sdat[d][p][(edge_n + d) % 8] = (int'(s_addr[p]) < dep(d)) ? mmem[d][s_addr[p]] : 32'h0;
               end
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
               if (m_acc[p] && s_wr[p] && int'(s_addr[p]) < dep(d))
                  for (int b = 0; b < 4; b++)
                     if (s_be[p][b]) mmem[d][s_addr[p]][8*b +: 8] = s_wd[p][8*b +: 8];
         if (ready < 2) ready++;
         edge_n++;
      end
   end

   always @(negedge clk) begin : cmp
      int slot;
      if (chk_en) begin
         slot = (edge_n + 7) % 8;
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               if (sv[d][p][slot]) last[d][p] = sdat[d][p][slot];
               chk($sformatf("d%0d_s%0d_valid", d, p + 1), 32'(o_v[d][p]), 32'(sv[d][p][slot]));
               chk($sformatf("d%0d_s%0d_readdata", d, p + 1), o_rd[d][p], last[d][p]);
               chk($sformatf("d%0d_s%0d_waitrequest", d, p + 1), 32'(o_w[d][p]), 32'(m_wait(p)));
               sv[d][p][slot] = 1'b0;
            end
            chk($sformatf("d%0d_collision_count", d), 32'(o_cnt[d]), 32'(mcnt));
         end
      end
   end

   task automatic idle();
      for (int p = 0; p < 2; p++) begin
         s_cs[p] = 1'b0; s_rd[p] = 1'b0; s_wr[p] = 1'b0; s_ce[p] = 1'b1;
         s_be[p] = 4'hF; s_addr[p] = '0; s_wd[p] = '0;
      end
   endtask

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         #1;
      end
   endtask

   task automatic cmd(int p, bit w, bit r, logic [9:0] a, logic [31:0] dt, logic [3:0] be);
      s_cs[p] = 1'b1; s_wr[p] = w; s_rd[p] = r; s_addr[p] = a; s_wd[p] = dt; s_be[p] = be;
   endtask

   task automatic do_wr(int p, logic [9:0] a, logic [31:0] dt, logic [3:0] be = 4'hF);
      cmd(p, 1'b1, 1'b0, a, dt, be);
      step();
      idle();
   endtask

   task automatic do_rd(int p, logic [9:0] a);
      cmd(p, 1'b0, 1'b1, a, 32'h0, 4'hF);
      step();
      idle();
      step(2);
   endtask

   int pa, pb;

   initial begin
      idle();
      reset_n = 1'b0;
      chk_en = 1'b1;
      step(2);
      chk("rst_waitrequest", 32'(o_w[0][0]), 32'd1);
      chk("rst_valid", 32'(o_v[1][1]), 32'd0);
      chk("rst_readdata", o_rd[1][1], 32'h0);
      chk("rst_count", 32'(o_cnt[0]), 32'd0);
      reset_n = 1'b1;
      step();
      chk("sync_wait_edge1", 32'(o_w[0][0]), 32'd1);
      step();
      chk("sync_wait_edge2", 32'(o_w[0][0]), 32'd0);

      cmd(0, 1'b1, 1'b0, 10'd5, 32'hDEADBEEF, 4'hF);
      step();
      idle();
      cmd(1, 1'b0, 1'b1, 10'd5, 32'h0, 4'hF);
      step();
      idle();
      chk("lat1_valid", 32'(o_v[0][1]), 32'd1);
      chk("lat1_data", o_rd[0][1], 32'hDEADBEEF);
      chk("lat2_not_yet", 32'(o_v[1][1]), 32'd0);
      step();
      chk("lat1_single_pulse", 32'(o_v[0][1]), 32'd0);
      chk("lat2_valid", 32'(o_v[1][1]), 32'd1);
      chk("lat2_data", o_rd[1][1], 32'hDEADBEEF);

      cmd(0, 1'b1, 1'b0, 10'h3FF, 32'h11111111, 4'hF);
      cmd(1, 1'b1, 1'b0, 10'h3FF, 32'h22222222, 4'hF);
      #1;
      chk("col_s2_wait", 32'(o_w[0][1]), 32'd1);
      chk("col_s1_wait", 32'(o_w[0][0]), 32'd0);
      step();
      s_cs[0] = 1'b0; s_wr[0] = 1'b0;
      #1;
      chk("col_s2_released", 32'(o_w[1][1]), 32'd0);
      step();
      idle();
      chk("col_count_a", 32'(o_cnt[0]), 32'd1);
      chk("col_count_b", 32'(o_cnt[1]), 32'd1);
      do_rd(0, 10'h3FF);
      chk("col_final_b", o_rd[1][0], 32'h22222222);
      chk("col_oor_a", o_rd[0][0], 32'h0);

      do_wr(0, 10'd7, 32'hAAAAAAAA);
      cmd(0, 1'b1, 1'b0, 10'd7, 32'h55555555, 4'hF);
      cmd(1, 1'b0, 1'b1, 10'd7, 32'h0, 4'hF);
      step();
      idle();
      step(2);
      chk("rdw_old_a", o_rd[0][1], 32'hAAAAAAAA);
      chk("rdw_old_b", o_rd[1][1], 32'hAAAAAAAA);
      do_rd(1, 10'd7);
      chk("rdw_new_a", o_rd[0][1], 32'h55555555);
      chk("rdw_new_b", o_rd[1][1], 32'h55555555);

      do_wr(0, 10'd0, 32'h0);
      do_wr(0, 10'd0, 32'hFFFFFFFF, 4'b0101);
      do_rd(1, 10'd0);
      chk("be_0101", o_rd[0][1], 32'h00FF00FF);
      do_wr(1, 10'd0, 32'hFFFFFFFF, 4'b0000);
      do_rd(0, 10'd0);
      chk("be_zero", o_rd[1][0], 32'h00FF00FF);

      do_wr(0, 10'd999, 32'h99999999);
      do_wr(0, 10'd1000, 32'h12345678);
      cmd(0, 1'b0, 1'b1, 10'd1000, 32'h0, 4'hF);
      step();
      idle();
      chk("oor_valid", 32'(o_v[0][0]), 32'd1);
      chk("oor_data", o_rd[0][0], 32'h0);
      step(2);
      chk("oor_inrange_b", o_rd[1][0], 32'h12345678);
      do_rd(1, 10'd999);
      chk("oor_word999", o_rd[0][1], 32'h99999999);
      do_rd(1, 10'd0);
      chk("oor_word0", o_rd[0][1], 32'h00FF00FF);

      cmd(0, 1'b1, 1'b0, 10'd20, 32'hA0A0A0A0, 4'hF);
      cmd(1, 1'b1, 1'b0, 10'd21, 32'hB1B1B1B1, 4'hF);
      step();
      idle();
      do_rd(0, 10'd21);
      chk("dual_wr_21", o_rd[1][0], 32'hB1B1B1B1);
      do_rd(1, 10'd20);
      chk("dual_wr_20", o_rd[1][1], 32'hA0A0A0A0);

      cmd(0, 1'b1, 1'b1, 10'd22, 32'hCAFEF00D, 4'hF);
      step();
      idle();
      chk("rw_no_valid_a", 32'(o_v[0][0]), 32'd0);
      step();
      chk("rw_no_valid_b", 32'(o_v[1][0]), 32'd0);
      do_rd(1, 10'd22);
      chk("rw_is_write", o_rd[0][1], 32'hCAFEF00D);

      reset_req = 1'b1;
      cmd(0, 1'b0, 1'b1, 10'd5, 32'h0, 4'hF);
      #1;
      chk("freeze_wait", 32'(o_w[0][0]), 32'd1);
      step();
      reset_req = 1'b0;
      idle();
      chk("freeze_no_read", 32'(o_v[0][0]), 32'd0);
      s_ce[1] = 1'b0;
      cmd(1, 1'b1, 1'b0, 10'd5, 32'h0, 4'hF);
      step();
      idle();
      do_rd(0, 10'd5);
      chk("clken_blocks_write", o_rd[0][0], 32'hDEADBEEF);

      for (int i = 0; i < 16; i++) do_wr(1, 10'(32 + i), 32'h1000 + 32'(i));
      pa = 0;
      pb = 0;
      for (int i = 0; i < 16; i++) begin
         cmd(0, 1'b0, 1'b1, 10'(32 + i), 32'h0, 4'hF);
         step();
         pa += int'(o_v[0][0]);
         pb += int'(o_v[1][0]);
      end
      idle();
      for (int i = 0; i < 2; i++) begin
         step();
         pa += int'(o_v[0][0]);
         pb += int'(o_v[1][0]);
      end
      chk("burst_pulses_a", 32'(pa), 32'd16);
      chk("burst_pulses_b", 32'(pb), 32'd16);
      chk("burst_last", o_rd[1][0], 32'h100F);

      for (int i = 0; i < 6; i++) begin
         cmd(0, 1'b0, 1'b1, 10'(32 + i), 32'h0, 4'hF);
         if (i == 5) cmd(1, 1'b1, 1'b0, 10'd50, 32'h5050, 4'hF);
         step();
         s_cs[1] = 1'b0; s_wr[1] = 1'b0;
      end
      reset_n = 1'b0;
      idle();
      #1;
      chk("midrst_valid_a", 32'(o_v[0][0]), 32'd0);
      chk("midrst_valid_b", 32'(o_v[1][0]), 32'd0);
      chk("midrst_data_a", o_rd[0][0], 32'h0);
      chk("midrst_data_b", o_rd[1][0], 32'h0);
      chk("midrst_count", 32'(o_cnt[1]), 32'd0);
      step(2);
      reset_n = 1'b1;
      step(3);
      chk("post_rst_count", 32'(o_cnt[0]), 32'd0);
      do_rd(0, 10'd50);
      chk("pre_rst_write_a", o_rd[0][0], 32'h5050);
      chk("pre_rst_write_b", o_rd[1][0], 32'h5050);
      do_rd(1, 10'd32);
      chk("mem_kept_32", o_rd[1][1], 32'h1000);
      do_rd(0, 10'd7);
      chk("mem_kept_7", o_rd[0][0], 32'h55555555);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
